// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus definitions: FSM state encoding, default window constants
// and the address window decode used by the RAM bridge.
package z80_bus_pkg;

  localparam int unsigned DEF_ADDR_W    = 32'd11;
  localparam logic [15:0] DEF_BASE_ADDR = 16'h0000;

  localparam logic [2:0] ST_IDLE_C     = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE_C = 3'd1;
  localparam logic [2:0] ST_RD_CAPT_C  = 3'd2;
  localparam logic [2:0] ST_WR_ISSUE_C = 3'd3;
  localparam logic [2:0] ST_HOLD_C     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = ST_IDLE_C,
    ST_RD_ISSUE = ST_RD_ISSUE_C,
    ST_RD_CAPT  = ST_RD_CAPT_C,
    ST_WR_ISSUE = ST_WR_ISSUE_C,
    ST_HOLD     = ST_HOLD_C
  } state_e;

  // True when addr falls in the 2**aw byte window starting at base.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int unsigned aw);
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/z80_ram_bridge_if.sv
// Z80 CPU-side memory bus: the CPU is the master, the RAM bridge the slave.
interface z80_ram_bridge_if #(
  parameter int unsigned DATA_W = 32'd8
);
  logic              mreq_n;
  logic              rd_n;
  logic              wr_n;
  logic [15:0]       addr;
  logic [DATA_W-1:0] cpu_dout;
  logic [DATA_W-1:0] cpu_din;
  logic              sel;
  logic              wait_n;

  modport master (
    output mreq_n, rd_n, wr_n, addr, cpu_dout,
    input  cpu_din, sel, wait_n
  );

  modport slave (
    input  mreq_n, rd_n, wr_n, addr, cpu_dout,
    output cpu_din, sel, wait_n
  );
endinterface

// File: rtl/z80_ram_bridge_access_detect.sv
// Turns a level "access active" condition into single-clk read/write start
// pulses; a write wins when both strobes are low.
module z80_access_detect (
  input  logic clk,
  input  logic reset,
  input  logic hit_i,
  input  logic rd_n_i,
  input  logic wr_n_i,
  output logic rd_start_o,
  output logic wr_start_o
);

  logic act_s;
  logic act_q;

  assign act_s = hit_i && (!rd_n_i || !wr_n_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q <= 1'b0;
    end else begin
      act_q <= act_s;
    end
  end

  assign wr_start_o = act_s && !act_q && !wr_n_i;
  assign rd_start_o = act_s && !act_q && wr_n_i;

endmodule

// File: rtl/z80_ram_bridge.sv
// Z80 memory bus to synchronous block RAM bridge, one RAM access per bus cycle.
// Optional wait-state generation for reads: define Z80_RAM_BRIDGE_WAIT_EN.
module z80_ram_bridge
  import z80_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = 32'd8
) (
  input  logic              clk,
  input  logic              reset,
  z80_ram_bridge_if.slave   bus,
  output logic              ram_ce_o,
  output logic              ram_oce_o,
  output logic              ram_wre_o,
  output logic [ADDR_W-1:0] ram_ad_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  state_e            state_q;
  logic              ce_q;
  logic              oce_q;
  logic              wre_q;
  logic [ADDR_W-1:0] ad_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] cpu_din_q;

  logic hit_s;
  logic bus_idle_s;
  logic rd_start_s;
  logic wr_start_s;

  assign hit_s      = !bus.mreq_n && in_window(bus.addr, BASE_ADDR, ADDR_W);
  assign bus_idle_s = bus.mreq_n || (bus.rd_n && bus.wr_n);

  z80_access_detect u_detect (
    .clk        (clk),
    .reset      (reset),
    .hit_i      (hit_s),
    .rd_n_i     (bus.rd_n),
    .wr_n_i     (bus.wr_n),
    .rd_start_o (rd_start_s),
    .wr_start_o (wr_start_s)
  );

  // Access sequencer; RAM strobes are single-clk and default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ce_q      <= 1'b0;
      oce_q     <= 1'b0;
      wre_q     <= 1'b0;
      ad_q      <= '0;
      din_q     <= '0;
      cpu_din_q <= '0;
    end else begin
      ce_q  <= 1'b0;
      oce_q <= 1'b0;
      wre_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_start_s) begin
            ce_q    <= 1'b1;
            wre_q   <= 1'b1;
            ad_q    <= bus.addr[ADDR_W-1:0];
            din_q   <= bus.cpu_dout;
            state_q <= ST_WR_ISSUE;
          end else if (rd_start_s) begin
            ce_q    <= 1'b1;
            ad_q    <= bus.addr[ADDR_W-1:0];
            state_q <= ST_RD_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD_ISSUE: begin
          oce_q   <= 1'b1;
          state_q <= ST_RD_CAPT;
        end
        // Capture completes even if the CPU already abandoned the cycle.
        ST_RD_CAPT: begin
          cpu_din_q <= ram_dout_i;
          state_q   <= bus_idle_s ? ST_IDLE : ST_HOLD;
        end
        ST_WR_ISSUE: begin
          state_q <= bus_idle_s ? ST_IDLE : ST_HOLD;
        end
        ST_HOLD: begin
          state_q <= bus_idle_s ? ST_IDLE : ST_HOLD;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef Z80_RAM_BRIDGE_WAIT_EN
  logic wait_n_q;

  // Stall the CPU from the read start clk until cpu_din has been captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_n_q <= 1'b1;
    end else begin
      wait_n_q <= !(((state_q == ST_IDLE) && rd_start_s) || (state_q == ST_RD_ISSUE));
    end
  end

  assign bus.wait_n = wait_n_q;
`else
  assign bus.wait_n = 1'b1;
`endif

  assign bus.sel     = hit_s;
  assign bus.cpu_din = cpu_din_q;
  assign ram_ce_o    = ce_q;
  assign ram_oce_o   = oce_q;
  assign ram_wre_o   = wre_q;
  assign ram_ad_o    = ad_q;
  assign ram_din_o   = din_q;

endmodule
